// File: rtl/ln_pkg.sv
// ln_pkg -- shared constants and types for the ln reconstruction scheduler.
//
// Contents:
//   LN2          33-bit fixed-point ln(2) constant used by the datapath
//   EXP_W/Y_W/E_W operand and result widths
//   P_W/D_W      internal product / difference widths
//   OPCNT_W      width of the optional completed-op counter
//   schedState_t scheduler FSM state encoding
//
// Optional feature macro used by this slice: LN_SCHED_PERF_EN.
package ln_pkg;

    localparam int EXP_W   = 6;
    localparam int Y_W     = 28;
    localparam int E_W     = 31;
    localparam int P_W     = 39;
    localparam int D_W     = 34;
    localparam int OPCNT_W = 16;

    localparam logic [32:0] LN2 = 33'h0B1724745;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } schedState_t;

endpackage

// File: rtl/ln_recon_dp.sv
// ln_recon_dp -- combinational ln reconstruction datapath.
//
// Computes P = exp * LN2 (39 bit), D = P[38:5] - y modulo 2^34 and returns
// D[32:2]. Underflow simply wraps; no error is flagged here.
//
// Ports:
//   iExp  [EXP_W-1:0]  unsigned exponent
//   iY    [Y_W-1:0]    unsigned reduced-argument term
//   oE    [E_W-1:0]    reconstructed result
module ln_recon_dp
    import ln_pkg::*;
(
    input  logic [EXP_W-1:0] iExp,
    input  logic [Y_W-1:0]   iY,
    output logic [E_W-1:0]   oE
);

    logic [P_W-1:0] prod;
    logic [D_W-1:0] diff;
    logic           unusedBits;

    assign prod = P_W'(iExp) * P_W'(LN2);
    // Both operands are 34 bits wide so the subtraction wraps modulo 2^34.
    assign diff = prod[P_W-1:5] - {6'b0, iY};
    assign oE   = diff[32:2];

    // Guard bits below the result LSB and the top wrap bit are dropped.
    assign unusedBits = ^{prod[4:0], diff[D_W-1], diff[1:0]};

endmodule

// File: rtl/ln_recon_sched.sv
// ln_recon_sched -- two-requester scheduler around the ln reconstruction
// datapath. One transaction is outstanding at a time; the FSM walks
// IDLE -> ISSUE -> CAPTURE -> HOLD -> IDLE.
//
// Ports:
//   iClk, iRst_n                 clock (rising edge), async active-low reset
//   iReqk_valid / oReqk_ready    request handshake for requester k in {0,1}
//   iReqk_exp, iReqk_y           operands, sampled only on handshake
//   iReqk_sign                   operand sign; 1 marks the operand invalid
//   oRes_valid / iRes_ready      result handshake
//   oRes_e                       reconstructed result (0 when invalid)
//   oRes_id                      index of the requester that was served
//   oRes_err                     set for an invalid (sign=1) operand
//   oBusy                        high whenever the FSM is not in IDLE
//   oOp_cnt                      saturating completed-op count
//                                (only when LN_SCHED_PERF_EN is defined)
//
// Configuration macro: LN_SCHED_PERF_EN enables the completed-op counter.
module ln_recon_sched
    import ln_pkg::*;
(
    input  logic               iClk,
    input  logic               iRst_n,

    input  logic               iReq0_valid,
    output logic               oReq0_ready,
    input  logic [EXP_W-1:0]   iReq0_exp,
    input  logic [Y_W-1:0]     iReq0_y,
    input  logic               iReq0_sign,

    input  logic               iReq1_valid,
    output logic               oReq1_ready,
    input  logic [EXP_W-1:0]   iReq1_exp,
    input  logic [Y_W-1:0]     iReq1_y,
    input  logic               iReq1_sign,

    output logic               oRes_valid,
    input  logic               iRes_ready,
    output logic [E_W-1:0]     oRes_e,
    output logic               oRes_id,
    output logic               oRes_err,
    output logic               oBusy
`ifdef LN_SCHED_PERF_EN
    ,
    output logic [OPCNT_W-1:0] oOp_cnt
`endif
);

    schedState_t      state;
    schedState_t      nextState;

    logic             lastGrant;
    logic             grantId;
    logic             reqHs;
    logic             loadOp;
    logic             loadRes;
    logic             clrRes;

    logic [EXP_W-1:0] opExp_p0;
    logic [Y_W-1:0]   opY_p0;
    logic             opSign_p0;
    logic             opId_p0;

    logic [E_W-1:0]   dpE;

    // Round-robin: a lone valid requester wins; with both valid, the one
    // not served last wins. lastGrant resets to 1 so requester 0 goes first.
    assign grantId     = iReq1_valid & (~iReq0_valid | ~lastGrant);
    assign oReq0_ready = (state == IDLE) & iReq0_valid & ~grantId;
    assign oReq1_ready = (state == IDLE) & grantId;
    assign reqHs       = (oReq0_ready & iReq0_valid) | (oReq1_ready & iReq1_valid);
    assign oBusy       = (state != IDLE);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        loadOp    = 1'b0;
        loadRes   = 1'b0;
        clrRes    = 1'b0;
        case (state)
            IDLE: begin
                if (reqHs) begin
                    loadOp    = 1'b1;
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                nextState = CAPTURE;
            end
            CAPTURE: begin
                loadRes   = 1'b1;
                nextState = HOLD;
            end
            HOLD: begin
                if (iRes_ready) begin
                    clrRes    = 1'b1;
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            lastGrant <= 1'b1;
        end else if (loadOp) begin
            lastGrant <= grantId;
        end
    end

    // ---- stage p0: operands captured at the request handshake ----
    always_ff @(posedge iClk) begin
        if (loadOp) begin
            opExp_p0  <= grantId ? iReq1_exp  : iReq0_exp;
            opY_p0    <= grantId ? iReq1_y    : iReq0_y;
            opSign_p0 <= grantId ? iReq1_sign : iReq0_sign;
            opId_p0   <= grantId;
        end
    end

    ln_recon_dp uDp (
        .iExp (opExp_p0),
        .iY   (opY_p0),
        .oE   (dpE)
    );

    // ---- stage p1: datapath result captured, held until accepted ----
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oRes_valid <= 1'b0;
            oRes_e     <= '0;
            oRes_id    <= 1'b0;
            oRes_err   <= 1'b0;
        end else if (loadRes) begin
            oRes_valid <= 1'b1;
            oRes_e     <= opSign_p0 ? '0 : dpE;
            oRes_id    <= opId_p0;
            oRes_err   <= opSign_p0;
        end else if (clrRes) begin
            oRes_valid <= 1'b0;
        end
    end

`ifdef LN_SCHED_PERF_EN
    logic [OPCNT_W-1:0] opCnt;

    function automatic logic [OPCNT_W-1:0] satInc(input logic [OPCNT_W-1:0] v);
        return (&v) ? v : v + OPCNT_W'(1);
    endfunction

    // Every accepted result counts, including sign-error results.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            opCnt <= '0;
        end else if (oRes_valid & iRes_ready) begin
            opCnt <= satInc(opCnt);
        end
    end

    assign oOp_cnt = opCnt;
`endif

endmodule
